// File: rtl/ram_8_16_pkg.sv
// Shared definitions for the 8x16 RAM built-in self-test.
// Contents: RAM geometry, the BIST FSM state type and the march pattern
// generator used both to drive write data and to form expected read data.
package ram_8_16_pkg;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // Phase 0 writes seed+addr, phase 1 writes the inverse so every cell
    // sees each bit in both polarities.
    function automatic logic [DW-1:0] pattern(input logic [DW-1:0] seed,
                                              input logic [AW-1:0] a,
                                              input logic          ph);
        logic [DW-1:0] v;
        v = seed + {{(DW-AW){1'b0}}, a};
        return ph ? ~v : v;
    endfunction

endpackage

// File: rtl/ram_8_16_bist_cmp_pipe.sv
// Read-compare pipeline for the RAM BIST.
// Delays {valid, addr, expected} by READ_LAT cycles so the entry lines up
// with the RAM's registered data_out, then compares.
// Ports:
//   clk, clr          clock, async active-high reset (flushes the pipeline)
//   in_valid/addr/exp read issued this cycle, its address and expected data
//   data_out          RAM read data
//   mis, mis_addr     miscompare strobe and the address that miscompared
module bist_cmp_pipe
    import ram_8_16_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    input  logic [DW-1:0] data_out,
    output logic          mis,
    output logic [AW-1:0] mis_addr
);

    logic          v_q [READ_LAT];
    logic [AW-1:0] a_q [READ_LAT];
    logic [DW-1:0] e_q [READ_LAT];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < READ_LAT; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                e_q[i] <= '0;
            end
        end else begin
            v_q[0] <= in_valid;
            a_q[0] <= in_addr;
            e_q[0] <= in_exp;
            for (int i = 1; i < READ_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                e_q[i] <= e_q[i-1];
            end
        end
    end

    // The last stage is valid in exactly the cycle data_out carries the read.
    assign mis      = v_q[READ_LAT-1] && (data_out != e_q[READ_LAT-1]);
    assign mis_addr = a_q[READ_LAT-1];

endmodule

// File: rtl/ram_8_16_bist.sv
// Built-in self-test initiator for the 8-word x 16-bit dual-port RAM.
// Runs a two-phase write/read-back march (pattern, then inverted pattern)
// over both RAM ports and reports pass/fail with a saturating error count.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold
// WRITE  | 8 cycles writing P(addr,ph) to addr 0..7
// READ   | 8 cycles reading addr 0..7 into the compare pipeline
// DRAIN  | READ_LAT cycles letting the last reads retire
// FINISH | one cycle, done pulse
//
// Ports:
//   clk, clr               clock, async active-high reset
//   start, seed            run request (honoured only in IDLE), pattern seed
//   we, wr_addr, data_in   RAM write port
//   re, rd_addr, data_out  RAM read port
//   busy, done, pass       run status and result
//   fail_addr, err_count   first failing address, saturating miscompare count
module ram_8_16_bist
    import ram_8_16_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ERR_W    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [DW-1:0]    seed,
    output logic             we,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    data_in,
    output logic             re,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    data_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_addr,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
    localparam logic [1:0]    DRAIN_INIT = 2'(READ_LAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, addr_inc;
    logic [1:0]    drain_q, drain_d;
    logic          ph_q, ph_d;
    logic [DW-1:0] seed_q, seed_d;

    logic             we_d, re_d, busy_d, done_d, pass_d;
    logic [AW-1:0]    wr_addr_d, rd_addr_d;
    logic [DW-1:0]    data_in_d;

    logic             accept;
    logic             mis;
    logic [AW-1:0]    mis_addr;
    logic             first_fail_q;
    logic             err_inc;
    logic [ERR_W-1:0] err_next;

    assign accept   = (state_q == ST_IDLE) && start;
    assign addr_inc = addr_q + AW'(1);
    assign err_inc  = mis && (err_count != {ERR_W{1'b1}});
    assign err_next = err_count + {{(ERR_W-1){1'b0}}, err_inc};

    bist_cmp_pipe #(.READ_LAT(READ_LAT)) u_cmp (
        .clk      (clk),
        .clr      (clr),
        .in_valid (re),
        .in_addr  (rd_addr),
        .in_exp   (pattern(seed_q, rd_addr, ph_q)),
        .data_out (data_out),
        .mis      (mis),
        .mis_addr (mis_addr)
    );

    // Next-state logic also computes the next value of every registered
    // output, so the RAM sees clean flop outputs aligned with the state.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        ph_d      = ph_q;
        seed_d    = seed_q;
        we_d      = 1'b0;
        wr_addr_d = '0;
        data_in_d = '0;
        re_d      = 1'b0;
        rd_addr_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pass_d    = pass;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WRITE;
                    seed_d    = seed;
                    ph_d      = 1'b0;
                    addr_d    = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    data_in_d = pattern(seed, '0, 1'b0);
                end
            end
            ST_WRITE: begin
                busy_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    re_d    = 1'b1;
                end else begin
                    addr_d    = addr_inc;
                    we_d      = 1'b1;
                    wr_addr_d = addr_inc;
                    data_in_d = pattern(seed_q, addr_inc, ph_q);
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end else begin
                    addr_d    = addr_inc;
                    re_d      = 1'b1;
                    rd_addr_d = addr_inc;
                end
            end
            ST_DRAIN: begin
                if (drain_q != 2'd0) begin
                    busy_d  = 1'b1;
                    drain_d = drain_q - 2'd1;
                end else if (!ph_q) begin
                    state_d   = ST_WRITE;
                    ph_d      = 1'b1;
                    addr_d    = '0;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    data_in_d = pattern(seed_q, '0, 1'b1);
                end else begin
                    // The final compare retires on this same edge, hence err_next.
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    pass_d  = (err_next == '0);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            drain_q <= '0;
            ph_q    <= 1'b0;
            seed_q  <= '0;
            we      <= 1'b0;
            wr_addr <= '0;
            data_in <= '0;
            re      <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            ph_q    <= ph_d;
            seed_q  <= seed_d;
            we      <= we_d;
            wr_addr <= wr_addr_d;
            data_in <= data_in_d;
            re      <= re_d;
            rd_addr <= rd_addr_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_count    <= '0;
            fail_addr    <= '0;
            first_fail_q <= 1'b0;
        end else if (accept) begin
            err_count    <= '0;
            fail_addr    <= '0;
            first_fail_q <= 1'b0;
        end else if (mis) begin
            err_count <= err_next;
            if (!first_fail_q) begin
                fail_addr    <= mis_addr;
                first_fail_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_8_16_bist.sv
// Self-checking bench for ram_8_16_bist with a behavioural RAM beside it.
// The RAM model can be clean, have addr 5 bit 0 stuck at 1, or return a
// constant 0x1234. Expected writes and run results go into queues; a
// monitor pops and compares whenever the DUT writes or pulses done.
module tb_ram_8_16_bist;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [15:0] seed;
    logic        we, re, busy, done, pass;
    logic [2:0]  wr_addr, rd_addr, fail_addr;
    logic [15:0] data_in, data_out;
    logic [3:0]  err_count;

    ram_8_16_bist #(.READ_LAT(RL), .ERR_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .seed      (seed),
        .we        (we),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .re        (re),
        .rd_addr   (rd_addr),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: mode 0 clean, 1 addr 5 bit 0 stuck-at-1, 2 constant output.
    int          mode = 0;
    logic [15:0] mem [8];
    logic [15:0] rd_q = 16'h0;
    always @(posedge clk) begin
        if (we) mem[wr_addr] <= (mode == 1 && wr_addr == 3'd5) ? (data_in | 16'h0001) : data_in;
        if (re) rd_q <= mem[rd_addr];
    end
    assign data_out = (mode == 2) ? 16'h1234 : rd_q;

    typedef struct {
        logic       pass;
        logic [2:0] fa;
        logic [3:0] ec;
        int         done_cyc;
    } res_t;

    logic [18:0] wq [$];
    res_t        rq [$];
    int n_chk = 0;
    int n_ok  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_ok++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [18:0] w_exp;
    res_t        r_exp;
    always @(negedge clk) begin
        if (we && re) check("we_re_exclusive", re, 0);
        if (we) begin
            if (wq.size() == 0) check("write_unexpected", we, 0);
            else begin
                w_exp = wq.pop_front();
                check("write_addr_data", {13'd0, wr_addr, data_in}, {13'd0, w_exp});
            end
        end
        if (done) begin
            if (rq.size() == 0) check("done_unexpected", done, 0);
            else begin
                r_exp = rq.pop_front();
                check("pass", pass, r_exp.pass);
                check("fail_addr", fail_addr, r_exp.fa);
                check("err_count", err_count, r_exp.ec);
                check("done_cycle", cyc, r_exp.done_cyc);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_test(input logic [15:0] s, input int m, input logic ep,
                            input logic [2:0] efa, input logic [3:0] eec,
                            input int restart_at, input int clr_at);
        int   acc;
        int   k;
        bit   cut;
        res_t r;
        mode = m;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] v;
            v = (i < 8) ? s + 16'(i) : ~(s + 16'(i - 8));
            wq.push_back({3'(i % 8), v});
        end
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        check("busy_cycle1", busy, 1);
        if (clr_at == 0) begin
            r.pass     = ep;
            r.fa       = efa;
            r.ec       = eec;
            r.done_cyc = acc + 2 * (16 + RL);
            rq.push_back(r);
        end
        cut = 1'b0;
        k   = 1;
        while ((wq.size() != 0 || rq.size() != 0) && !cut && k < 150) begin
            @(negedge clk);
            k = cyc - acc + 1;
            if (k == restart_at) begin
                seed  = 16'hAAAA;
                start = 1'b1;
            end else if (k == restart_at + 1) begin
                start = 1'b0;
            end
            if (k == clr_at) begin
                check("re_before_clr", re, 1);
                clr = 1'b1;
                #1;
                check("clr_we", we, 0);
                check("clr_re", re, 0);
                check("clr_busy", busy, 0);
                check("clr_err_count", err_count, 0);
                @(negedge clk);
                clr = 1'b0;
                wq.delete();
                rq.delete();
                cut = 1'b1;
            end
        end
        if (!cut) begin
            if (wq.size() != 0 || rq.size() != 0) begin
                check("run_timeout", wq.size() + rq.size(), 0);
                wq.delete();
                rq.delete();
            end
            repeat (3) @(negedge clk);
            check("pass_held", pass, ep);
            check("idle_after_done", busy, 0);
        end
    endtask

    initial begin
        clr   = 1'b1;
        start = 1'b0;
        seed  = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_re", re, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_addrs", {wr_addr, rd_addr, fail_addr}, 0);
        check("rst_data_in", data_in, 0);
        check("rst_err_count", err_count, 0);
        clr = 1'b0;
        @(negedge clk);

        run_test(16'h0000, 0, 1'b1, 3'd0, 4'd0,  0, 0);
        run_test(16'h0000, 1, 1'b0, 3'd5, 4'd1,  0, 0);
        run_test(16'hFFFC, 0, 1'b1, 3'd0, 4'd0,  0, 0);
        run_test(16'h0000, 2, 1'b0, 3'd0, 4'd15, 0, 0);
        run_test(16'h1357, 0, 1'b1, 3'd0, 4'd0, 10, 0);
        repeat (40) @(negedge clk);
        check("no_second_run", busy, 0);
        run_test(16'h4242, 0, 1'b1, 3'd0, 4'd0,  0, 12);
        run_test(16'h4242, 0, 1'b1, 3'd0, 4'd0,  0, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
